instr_fetch: RTL and testbench



---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/instr_fetch_timer.sv | 33 +++
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: phase codes, NOP encoding, FSM states.
package instr_fetch_pkg;

  localparam logic [4:0] PhF = 5'b00001;
  localparam logic [4:0] PhD = 5'b00010;
  localparam logic [4:0] PhE = 5'b00100;
  localparam logic [4:0] PhM = 5'b01000;
  localparam logic [4:0] PhW = 5'b10000;

  localparam logic [31:0] NopInstr = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_timer.sv
// Request timeout counter: cleared when a request starts, counts REQ cycles without ack.
module instr_fetch_timer #(
  parameter int unsigned Timeout = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [7:0] tcnt_q, tcnt_d;

  always_comb begin
    tcnt_d = tcnt_q;
    if (clr_i) begin
      tcnt_d = '0;
    end else if (en_i) begin
      tcnt_d = tcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign expire_o = (tcnt_q == 8'(Timeout - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: samples PC in PH_F, runs a req/ack read on imem, latches IR, stalls decode.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned AddrW   = 32,
  parameter int unsigned DataW   = 32,
  parameter int unsigned Timeout = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       phase_i,
  input  logic [AddrW-1:0] pc_i,
  input  logic             hlt_i,
  output logic             imem_req_o,
  output logic [AddrW-1:0] imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [DataW-1:0] imem_rdata_i,
  output logic [DataW-1:0] ir_o,
  output logic             stall_o,
  output logic             fetch_err_o
);

  fetch_state_e     state_q, state_d;
  logic             req_q, req_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] ir_q, ir_d;
  logic             err_q, err_d;
  logic             tmr_clr, tmr_en, tmr_expire;

  instr_fetch_timer #(
    .Timeout(Timeout)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .expire_o(tmr_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      addr_q  <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    err_d   = err_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hlt_i) begin
          err_d = 1'b0;
        end else if (phase_i == PhF) begin
          addr_d = pc_i;
          if (pc_i[1:0] == 2'b00) begin
            req_d   = 1'b1;
            tmr_clr = 1'b1;
            state_d = StReq;
          end else begin
            err_d = 1'b1;
            ir_d  = DataW'(NopInstr);
          end
        end
      end
      StReq: begin
        if (imem_ack_i) begin
          ir_d    = imem_rdata_i;
          req_d   = 1'b0;
          state_d = StIdle;
        end else if (tmr_expire) begin
          // Timeout is the only case where a request is withdrawn without an ack.
          req_d   = 1'b0;
          ir_d    = DataW'(NopInstr);
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmr_en = 1'b1;
          if (hlt_i) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (imem_ack_i) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    stall_o = (phase_i == PhD) && (state_q != StIdle) && !hlt_i;
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign ir_o        = ir_q;
  assign fetch_err_o = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: zero-wait, wait states, misalign, timeout, halt drain, reset.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  phase;
  logic [31:0] pc;
  logic        hlt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        stall;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;

  instr_fetch #(
    .AddrW  (32),
    .DataW  (32),
    .Timeout(255)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .phase_i     (phase),
    .pc_i        (pc),
    .hlt_i       (hlt),
    .imem_req_o  (imem_req),
    .imem_addr_o (imem_addr),
    .imem_ack_i  (imem_ack),
    .imem_rdata_i(imem_rdata),
    .ir_o        (ir),
    .stall_o     (stall),
    .fetch_err_o (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch used to preload ir with a known value.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
    phase = PhF; pc = addr; hlt = 1'b0; imem_ack = 1'b0;
    step();
    phase = PhD; imem_ack = 1'b1; imem_rdata = data;
    step();
    imem_ack = 1'b0; phase = PhE;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    checks++; if (ir !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=0", ir); end
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", fetch_err); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    phase = PhF; pc = 32'h100;
    step();
    phase = PhD; imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL zw_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL zw_addr got=%h exp=100", imem_addr); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL zw_stall1 got=%b exp=1", stall); end
    step();
    imem_ack = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL zw_req_drop got=%b exp=0", imem_req); end
    checks++; if (ir !== 32'h8C22_0004) begin failures++; $display("FAIL zw_ir got=%h exp=8c220004", ir); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL zw_stall0 got=%b exp=0", stall); end
    // An ack seen in IDLE must not touch ir.
    imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    step();
    imem_ack = 1'b0;
    checks++; if (ir !== 32'h8C22_0004) begin failures++; $display("FAIL idle_ack_ir got=%h exp=8c220004", ir); end
  endtask

  task automatic test_wait_states();
    phase = PhF; pc = 32'h104;
    step();
    phase = PhD;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 3);
      imem_rdata = (i == 3) ? 32'h1234_5678 : 32'hFFFF_FFFF;
      #1;
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL ws_req[%0d] got=%b exp=1", i, imem_req); end
      checks++; if (imem_addr !== 32'h104) begin failures++; $display("FAIL ws_addr[%0d] got=%h exp=104", i, imem_addr); end
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ws_stall[%0d] got=%b exp=1", i, stall); end
      checks++; if (ir !== 32'h8C22_0004) begin failures++; $display("FAIL ws_ir_hold[%0d] got=%h exp=8c220004", i, ir); end
      step();
    end
    imem_ack = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL ws_req_drop got=%b exp=0", imem_req); end
    checks++; if (ir !== 32'h1234_5678) begin failures++; $display("FAIL ws_ir got=%h exp=12345678", ir); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ws_stall_end got=%b exp=0", stall); end
  endtask

  task automatic test_misaligned();
    phase = PhF; pc = 32'h102;
    step();
    phase = PhD;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mis_req got=%b exp=0", imem_req); end
    checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", fetch_err); end
    checks++; if (ir !== 32'h0) begin failures++; $display("FAIL mis_ir got=%h exp=0", ir); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mis_stall got=%b exp=0", stall); end
    phase = PhE; hlt = 1'b1;
    step();
    hlt = 1'b0;
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL mis_err_clear got=%b exp=0", fetch_err); end
  endtask

  task automatic test_timeout();
    int n;
    do_fetch(32'h1F0, 32'hCAFE_F00D);
    phase = PhF; pc = 32'h200;
    step();
    phase = PhD; imem_ack = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (imem_req !== 1'b1) break;
      n++;
      step();
    end
    checks++; if (n !== 255) begin failures++; $display("FAIL to_req_cycles got=%0d exp=255", n); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL to_req_drop got=%b exp=0", imem_req); end
    checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", fetch_err); end
    checks++; if (ir !== 32'h0) begin failures++; $display("FAIL to_ir got=%h exp=0", ir); end
    phase = PhE; hlt = 1'b1;
    step();
    hlt = 1'b0;
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL to_err_clear got=%b exp=0", fetch_err); end
  endtask

  task automatic test_halt_drain();
    do_fetch(32'h300, 32'h1111_1111);
    phase = PhF; pc = 32'h304;
    step();
    phase = PhD;
    step();
    hlt = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL hd_stall_req got=%b exp=0", stall); end
    step();
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL hd_req_drain got=%b exp=1", imem_req); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL hd_stall_drain got=%b exp=0", stall); end
    step();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL hd_req_hold got=%b exp=1", imem_req); end
    step();
    imem_ack = 1'b0; hlt = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL hd_req_drop got=%b exp=0", imem_req); end
    checks++; if (ir !== 32'h1111_1111) begin failures++; $display("FAIL hd_ir got=%h exp=11111111", ir); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL hd_idle_stall got=%b exp=0", stall); end
  endtask

  task automatic test_reset_mid_req();
    phase = PhF; pc = 32'h3FE;
    step();
    do_fetch(32'h3F0, 32'h7777_0000);
    phase = PhF; pc = 32'h400;
    step();
    phase = PhD; imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rr_req_pre got=%b exp=1", imem_req); end
    checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL rr_err_pre got=%b exp=1", fetch_err); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rr_req got=%b exp=0", imem_req); end
    checks++; if (ir !== 32'h0) begin failures++; $display("FAIL rr_ir got=%h exp=0", ir); end
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL rr_err got=%b exp=0", fetch_err); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rr_stall got=%b exp=0", stall); end
    #1;
    rst = 1'b0;
    do_fetch(32'h500, 32'hA5A5_A5A5);
    checks++; if (ir !== 32'hA5A5_A5A5) begin failures++; $display("FAIL rr_refetch_ir got=%h exp=a5a5a5a5", ir); end
    checks++; if (imem_addr !== 32'h500) begin failures++; $display("FAIL rr_refetch_addr got=%h exp=500", imem_addr); end
  endtask

  initial begin
    rst = 1'b1; phase = PhW; pc = '0; hlt = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_misaligned();
    test_timeout();
    test_halt_drain();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
